// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: request size codes, FSM
// state encoding and the byte-lane enable base masks.
package mau_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } mau_state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mau_load_align.sv
// Load lane extraction: shifts the addressed lane of a 32-bit RAM word down
// to bit 0 and sign- or zero-extends it according to the access size.
module mau_load_align
  import mau_pkg::*;
(
  input  logic [31:0] i_q,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [31:0] w_lane;
  logic        w_sign_b;
  logic        w_sign_h;

  assign w_lane   = i_q >> {i_offset, 3'b000};
  assign w_sign_b = ~i_unsigned & w_lane[7];
  assign w_sign_h = ~i_unsigned & w_lane[15];

  always_comb begin
    o_data = w_lane;
    case (i_size)
      SIZE_BYTE: o_data = {{24{w_sign_b}}, w_lane[7:0]};
      SIZE_HALF: o_data = {{16{w_sign_h}}, w_lane[15:0]};
      default:   o_data = w_lane;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store bus initiator for a byte-enable synchronous RAM: one request at
// a time, registered RAM-side outputs, one-cycle response pulse.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 14,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [31:0]              req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_error,
  output logic [3:0]               mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_data,
  input  logic [DATA_WIDTH-1:0]    mem_q
);

  mau_state_e r_state;
  mau_state_e w_next;

  logic [1:0]               r_offset;
  logic [1:0]               r_size;
  logic                     r_unsigned;
  logic                     r_write;
  logic                     r_rsp_valid;
  logic                     r_rsp_error;
  logic [DATA_WIDTH-1:0]    r_rsp_rdata;
  logic [3:0]               r_mem_we;
  logic [ADDRESS_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0]    r_mem_data;

  logic                     w_accept;
  logic                     w_err;
  logic [3:0]               w_store_we;
  logic [DATA_WIDTH-1:0]    w_store_data;
  logic [DATA_WIDTH-1:0]    w_load_data;
  logic                     w_unused_addr;

  // Upper byte-address bits are dropped so accesses wrap modulo the RAM size.
  assign w_unused_addr = ^req_addr[31:ADDRESS_WIDTH+2];

  assign w_accept = req_valid && (r_state == ST_IDLE);
  assign w_err    = (req_size == 2'b11)
                 || ((req_size == SIZE_HALF) && req_addr[0])
                 || ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));

  always_comb begin
    w_store_we   = BE_WORD;
    w_store_data = req_wdata;
    case (req_size)
      SIZE_BYTE: begin
        w_store_we   = BE_BYTE << req_addr[1:0];
        w_store_data = {4{req_wdata[7:0]}};
      end
      SIZE_HALF: begin
        w_store_we   = BE_HALF << req_addr[1:0];
        w_store_data = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  mau_load_align u_load_align (
    .i_q        (mem_q),
    .i_offset   (r_offset),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_load_data)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = w_err ? ST_RESP : ST_ISSUE;
      ST_ISSUE: w_next = r_write ? ST_RESP : ST_WAIT;
      ST_WAIT:  w_next = ST_RESP;
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Outputs are registered on the edge entering the state that presents them,
  // so mem_we is decided at accept time and is live exactly during ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_offset    <= '0;
      r_size      <= '0;
      r_unsigned  <= 1'b0;
      r_write     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_rdata <= '0;
      r_mem_we    <= '0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
    end else begin
      r_rsp_valid <= (w_next == ST_RESP);
      r_mem_we    <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_offset    <= req_addr[1:0];
            r_size      <= req_size;
            r_unsigned  <= req_unsigned;
            r_write     <= req_write;
            r_rsp_error <= w_err;
            r_rsp_rdata <= '0;
            if (!w_err) begin
              r_mem_addr <= req_addr[ADDRESS_WIDTH+1:2];
              if (req_write) begin
                r_mem_we   <= w_store_we;
                r_mem_data <= w_store_data;
              end
            end
          end
        end
        ST_WAIT: r_rsp_rdata <= w_load_data;
        ST_RESP: r_rsp_error <= 1'b0;
        default: ;
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_error = r_rsp_error;
  assign rsp_rdata = r_rsp_rdata;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_data  = r_mem_data;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit paired with a 16384x32 byte-enable synchronous
// RAM; expected responses come from a byte-addressed shadow memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [3:0]  mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_data;
  logic [31:0] mem_q;

  logic [31:0] ram    [0:16383];
  logic [7:0]  shadow [0:65535];

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          acc;
    int          lat;
  } rsp_exp_t;

  rsp_exp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_unit #(.ADDRESS_WIDTH(14), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_q        (mem_q)
  );

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_we[i]) ram[mem_addr][8*i +: 8] <= mem_data[8*i +: 8];
    mem_q <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns, input logic [15:0] ba);
    logic [7:0]  b;
    logic [15:0] h;
    case (sz)
      2'b00: begin
        b = shadow[ba];
        return uns ? {24'b0, b} : {{24{b[7]}}, b};
      end
      2'b01: begin
        h = {shadow[ba + 16'd1], shadow[ba]};
        return uns ? {16'b0, h} : {{16{h[15]}}, h};
      end
      default: return {shadow[ba + 16'd3], shadow[ba + 16'd2], shadow[ba + 16'd1], shadow[ba]};
    endcase
  endfunction

  always @(negedge clk) begin
    rsp_exp_t e;
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_error", 32'(rsp_error), 32'(e.err));
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input bit hold);
    rsp_exp_t    e;
    int          n;
    logic        err;
    logic        bad;
    logic [15:0] ba;
    logic [3:0]  we_exp;
    logic [31:0] d_exp;
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      check("ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    ba     = addr[15:0];
    err    = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
    we_exp = 4'b0000;
    d_exp  = 32'h0;
    e.err   = err;
    e.rdata = (err || wr) ? 32'h0 : model_load(sz, uns, ba);
    e.lat   = err ? 1 : (wr ? 2 : 3);
    e.acc   = cyc;
    exp_q.push_back(e);
    if (wr && !err) begin
      case (sz)
        2'b00: begin
          we_exp = 4'b0001 << addr[1:0];
          d_exp  = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
          shadow[ba] = wd[7:0];
        end
        2'b01: begin
          we_exp = 4'b0011 << addr[1:0];
          d_exp  = {wd[15:0], wd[15:0]};
          shadow[ba] = wd[7:0];
          shadow[ba + 16'd1] = wd[15:8];
        end
        default: begin
          we_exp = 4'b1111;
          d_exp  = wd;
          for (int i = 0; i < 4; i++) shadow[ba + 16'(i)] = wd[8*i +: 8];
        end
      endcase
    end
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    if (!err) begin
      check("issue_we", 32'(mem_we), 32'(we_exp));
      check("issue_addr", 32'(mem_addr), 32'(ba[15:2]));
      if (wr) check("issue_data", mem_data, d_exp);
    end else begin
      check("err_we", 32'(mem_we), 32'd0);
    end
    n   = 0;
    bad = 1'b0;
    while (!req_ready && n < 10) begin
      n++;
      @(posedge clk); #1;
      if (mem_we != 4'b0000) bad = 1'b1;
    end
    check("ready_low_cycles", 32'(n), 32'(e.lat));
    check("we_outside_issue", 32'(bad), 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
    for (int i = 0; i < 65536; i++) shadow[i] = 8'h0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_error", 32'(rsp_error), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_data", mem_data, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: word store/load, plus an aliased address above the RAM size
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 32'h0001_0010, 32'h0, 1'b0);
    // 2: byte lane 3
    do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_0080, 1'b0);
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0);
    do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0);
    // 3: upper half
    do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234_BEEF, 1'b0);
    do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b0);
    do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);
    // 4: error requests
    do_req(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 1'b0);
    do_req(1'b1, 2'b01, 1'b0, 32'h21, 32'hFFFF_FFFF, 1'b0);
    do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b0);
    do_req(1'b1, 2'b10, 1'b0, 32'h12, 32'h5555_5555, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    // 5: back-to-back with req_valid held high
    do_req(1'b1, 2'b10, 1'b0, 32'h30, 32'hA5A5_0F0F, 1'b1);
    do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b1);
    do_req(1'b1, 2'b00, 1'b0, 32'h31, 32'h0000_00C3, 1'b1);
    do_req(1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 1'b1);
    do_req(1'b0, 2'b00, 1'b0, 32'h33, 32'h0, 1'b0);

    // 6: reset during ISSUE of a store drops it
    do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFE_F00D, 1'b0);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h1234_5678;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_issue_we", 32'(mem_we), 32'hF);
    rst_n = 1'b0;
    #1;
    check("abort_we_cleared", 32'(mem_we), 32'd0);
    check("abort_ready_idle", 32'(req_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
